// File: rtl/alarm_pkg.sv
// Shared types, reset defaults and time-edit helpers for the alarm bank.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [3:0] hour;
    logic [5:0] min;
    logic       am_pm;
  } time12_t;

  localparam logic [3:0] DEF_HOUR  = 4'd6;
  localparam logic [5:0] DEF_MIN   = 6'd0;
  localparam logic       DEF_AM_PM = 1'b0;
  localparam time12_t    DEF_TIME  = '{hour: DEF_HOUR, min: DEF_MIN, am_pm: DEF_AM_PM};

  // 12-hour advance: 11 -> 12 flips AM/PM, 12 -> 1 does not.
  function automatic time12_t hour_inc(input time12_t t);
    time12_t r;
    r = t;
    if (t.hour == 4'd11) begin
      r.hour  = 4'd12;
      r.am_pm = ~t.am_pm;
    end else if (t.hour == 4'd12) begin
      r.hour = 4'd1;
    end else begin
      r.hour = t.hour + 4'd1;
    end
    return r;
  endfunction

  // Minute advance wraps 59 -> 0 without carrying into the hour.
  function automatic time12_t min_inc(input time12_t t);
    time12_t r;
    r = t;
    r.min = (t.min == 6'd59) ? 6'd0 : t.min + 6'd1;
    return r;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored time, enable, match detect and ring/snooze/timeout FSM.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN       = 9,
  parameter int RING_TIMEOUT_MIN = 5,
  parameter int CNT_W            = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    inc_hour,
  input  logic    inc_min,
  input  logic    toggle_en,
  input  time12_t curr_time,
  input  logic    mb,
  input  logic    snooze,
  input  logic    clear,
  output time12_t setting,
  output logic    enable,
  output logic    ringing,
  output logic    snoozed,
  output logic    missed
);

  localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_MIN);
  localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_TIMEOUT_MIN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  time12_t          set_q, set_d;
  logic             en_q, en_d;
  ch_state_e        st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             miss_q, miss_d;
  logic             timeout;
  logic             match;
  logic             disable_now;

  assign match       = mb && en_q && (curr_time == set_q);
  assign disable_now = toggle_en && en_q;

  // Settings edits; hour and minute strobes in one cycle both take effect.
  always_comb begin
    set_d = set_q;
    if (inc_hour) set_d = hour_inc(set_d);
    if (inc_min)  set_d = min_inc(set_d);
    en_d = en_q ^ toggle_en;
  end

  // Channel FSM: clear > disable > snooze > minute counting > match.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (clear || disable_now) begin
      st_d  = ST_IDLE;
      cnt_d = '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (match) begin
            st_d  = ST_RINGING;
            cnt_d = RING_LD;
          end
        end
        ST_RINGING: begin
          if (snooze) begin
            st_d  = ST_SNOOZED;
            cnt_d = SNOOZE_LD;
          end else if (mb) begin
            if (cnt_q == CNT_ONE) begin
              st_d    = ST_IDLE;
              cnt_d   = '0;
              timeout = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        ST_SNOOZED: begin
          if (mb) begin
            if (cnt_q == CNT_ONE) begin
              st_d  = ST_RINGING;
              cnt_d = RING_LD;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end
      endcase
    end
    miss_d = clear ? 1'b0 : (miss_q | timeout);
  end

  // State registers; reset restores 6:00 AM, disabled, idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_q  <= DEF_TIME;
      en_q   <= 1'b0;
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      miss_q <= 1'b0;
    end else begin
      set_q  <= set_d;
      en_q   <= en_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
    end
  end

  assign setting = set_q;
  assign enable  = en_q;
  assign ringing = (st_q == ST_RINGING);
  assign snoozed = (st_q == ST_SNOOZED);
  assign missed  = miss_q;

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm controller: sel decode, channel array, status aggregation.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter  int NUM_ALARMS       = 4,
  parameter  int SNOOZE_MIN       = 9,
  parameter  int RING_TIMEOUT_MIN = 5,
  localparam int SEL_W            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            curr_hour,
  input  logic [5:0]            curr_min,
  input  logic [5:0]            curr_sec,
  input  logic                  curr_am_pm,
  input  logic                  time_tick,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  inc_alarm_hour,
  input  logic                  inc_alarm_min,
  input  logic                  toggle_enable,
  input  logic                  alarm_snooze,
  input  logic                  alarm_clear,
  output logic                  alarm_on,
  output logic [NUM_ALARMS-1:0] ring_vec,
  output logic [NUM_ALARMS-1:0] snooze_vec,
  output logic [NUM_ALARMS-1:0] missed_vec,
  output logic [3:0]            sel_hour,
  output logic [5:0]            sel_min,
  output logic                  sel_am_pm,
  output logic                  sel_enable
);

  localparam int MAX_MIN = (SNOOZE_MIN > RING_TIMEOUT_MIN) ? SNOOZE_MIN : RING_TIMEOUT_MIN;
  localparam int CNT_W   = $clog2(MAX_MIN + 1);

  time12_t                curr_t;
  logic                   mb;
  time12_t                set_arr [NUM_ALARMS];
  logic [NUM_ALARMS-1:0]  en_vec;

  assign curr_t = '{hour: curr_hour, min: curr_min, am_pm: curr_am_pm};
  assign mb     = time_tick && (curr_sec == 6'd0);

  // Edit strobes reach only the addressed channel; out-of-range sel hits none.
  for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_ch
    logic hit;
    assign hit = (sel == SEL_W'(k));

    alarm_channel #(
      .SNOOZE_MIN       (SNOOZE_MIN),
      .RING_TIMEOUT_MIN (RING_TIMEOUT_MIN),
      .CNT_W            (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .inc_hour  (inc_alarm_hour && hit),
      .inc_min   (inc_alarm_min && hit),
      .toggle_en (toggle_enable && hit),
      .curr_time (curr_t),
      .mb        (mb),
      .snooze    (alarm_snooze),
      .clear     (alarm_clear),
      .setting   (set_arr[k]),
      .enable    (en_vec[k]),
      .ringing   (ring_vec[k]),
      .snoozed   (snooze_vec[k]),
      .missed    (missed_vec[k])
    );
  end

  // Display mux of the addressed channel's settings; zeros when sel is out of range.
  always_comb begin
    sel_hour   = '0;
    sel_min    = '0;
    sel_am_pm  = 1'b0;
    sel_enable = 1'b0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_hour   = set_arr[k].hour;
        sel_min    = set_arr[k].min;
        sel_am_pm  = set_arr[k].am_pm;
        sel_enable = en_vec[k];
      end
    end
  end

  assign alarm_on = |ring_vec;

endmodule
